// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: arbiter state encoding, default header tag, round-robin pick helper.
// Optional header-byte feature is selected in the top by UART_TX_ARB_TAG_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } arb_state_e;

    localparam logic [7:0]  UART_TAG_DEFAULT = 8'hF0;
    localparam int unsigned RR_MAX           = 8;

    // First asserted valid bit at or after ptr, wrapping at n-1; returns ptr if none.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        idx     = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if ((k < n) && !found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
            idx = (32'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle for the UART transmit arbiter.
// slave  : arbiter side (takes requests and tx_ready, drives handshakes and status).
// master : environment side (requesters plus transmitter).
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               timeout_pulse;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
    );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i, wrapping.
// Ports: valid_i (request vector), ptr_i (search start), idx_o (winner), any_o (any valid).
module rr_arbiter_pick
    import uart_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int unsigned IW = $clog2(N);

    logic [7:0] valid_ext;
    logic [2:0] pick;

    // Zero-extend to the helper's fixed 8-wide search space.
    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid_i;
    end

    assign pick  = rr_pick(valid_ext, 3'(ptr_i), N);
    assign idx_o = IW'(pick);
    assign any_o = |valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one byte-wide UART transmitter among N_REQ sources.
// Grant is held for a whole packet; a one-byte registered stage feeds the transmitter;
// an idle timeout releases a stalled owner mid-packet.
// Ports: clk, reset (sync, active-high), bus (uart_tx_arbiter_if.slave): req_valid/
//   req_data/req_last/req_ready, tx_data/tx_valid/tx_ready, grant_id, busy, timeout_pulse.
// Build option: UART_TX_ARB_TAG_EN inserts a TAG_BASE|grant_id header byte per packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned TIMEOUT  = 4095,
    parameter logic [7:0]  TAG_BASE = UART_TAG_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned GW     = $clog2(N_REQ);
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_e       state_q;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;
    logic             busy_q;
    logic             pulse_q;

    logic [GW-1:0]    pick_c;
    logic             any_c;
    logic             slot_free_c;
    logic             g_valid_c;
    logic             g_last_c;
    logic [7:0]       g_data_c;
    logic             accept_c;
    logic             load_c;
    logic [7:0]       load_data_c;
    logic [GW-1:0]    next_ptr_c;
    logic             timeout_hit_c;

    rr_arbiter_pick #(.N(N_REQ)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_c),
        .any_o   (any_c)
    );

    // Owner-side view of the request bundle and the handshake decode.
    assign slot_free_c   = !tx_valid_q || bus.tx_ready;
    assign g_valid_c     = bus.req_valid[grant_q];
    assign g_last_c      = bus.req_last[grant_q];
    assign g_data_c      = bus.req_data[{grant_q, 3'b000} +: 8];
    assign accept_c      = (state_q == XFER) && g_valid_c && slot_free_c;
    assign load_c        = accept_c || ((state_q == HDR) && slot_free_c);
    assign load_data_c   = (state_q == HDR) ? (TAG_BASE | 8'(grant_q)) : g_data_c;
    assign next_ptr_c    = (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + GW'(1);
    assign timeout_hit_c = (TIMEOUT != 0) && (state_q == XFER) && !g_valid_c
                           && (32'(cnt_q) == TO_LIM);

    // Only the owner sees ready, and only when the output stage can take a byte.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == XFER) begin
            bus.req_ready[grant_q] = slot_free_c;
        end
    end

    // Output stage plus packet FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            pulse_q <= 1'b0;

            // A load wins over a same-cycle drain so the stage never bubbles.
            if (load_c) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= load_data_c;
            end else if (tx_valid_q && bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (any_c) begin
                        grant_q <= pick_c;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef UART_TX_ARB_TAG_EN
                        state_q <= HDR;
`else
                        state_q <= XFER;
`endif
                    end
                end
                HDR: begin
                    if (slot_free_c) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (accept_c) begin
                        cnt_q <= '0;
                        if (g_last_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ptr_q   <= next_ptr_c;
                        end
                    end else if (timeout_hit_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= next_ptr_c;
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                    end else if ((TIMEOUT != 0) && !g_valid_c
                                 && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_valid      = tx_valid_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.grant_id      = grant_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_pulse = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the arbitration rules and against expected wire streams.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TO  = 8;
    localparam logic [7:0]  TAG = 8'hF0;
`ifdef UART_TX_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TAG_BASE(TAG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] srcq [N][$];
    logic [7:0] wire_q[$];
    logic [7:0] exp_q[$];
    int         rnd_mode = 0;
    logic       rdy_val  = 1'b1;
    int         last_acc;

    // Model: 0 = waiting for requests, 1 = header pending, 2 = moving packet bytes.
    int         m_state, m_g, m_ptr, m_idle;
    logic       m_txv, m_busy, m_pulse;
    logic [7:0] m_txd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_g = 0; m_ptr = 0; m_idle = 0;
        m_txv = 1'b0; m_txd = 8'h00; m_busy = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic enq(input int id, input int n, input logic [7:0] base, input bit with_last);
        for (int k = 0; k < n; k++)
            srcq[id].push_back({(with_last && (k == n - 1)), 8'(base + 8'(k))});
    endtask

    task automatic expp(input int id, input int n, input logic [7:0] base);
        if (TAG_ON) exp_q.push_back(TAG | 8'(id));
        for (int k = 0; k < n; k++) exp_q.push_back(8'(base + 8'(k)));
    endtask

    task automatic chk_wire(input string tag);
        chk({tag, "_len"}, 32'(wire_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < wire_q.size(); k++)
            chk({tag, "_byte"}, 32'(wire_q[k]), 32'(exp_q[k]));
        wire_q.delete();
        exp_q.delete();
    endtask

    // One clock: drive at negedge, check combinational ready, advance model, check registers.
    task automatic tick();
        logic [N-1:0]   v, l, exp_rr;
        logic [8*N-1:0] d;
        logic           rdy, slot, load, found;
        logic [7:0]     ld;
        v = '0; l = '0; d = '0; ld = 8'h00; load = 1'b0; found = 1'b0;
        last_acc = -1;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                v[i]        = (rnd_mode == 0) || ($urandom_range(0, 3) != 0);
                d[8*i +: 8] = srcq[i][0][7:0];
                l[i]        = srcq[i][0][8];
            end
        end
        rdy = (rnd_mode != 0) ? ($urandom_range(0, 2) != 0) : rdy_val;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.tx_ready  = rdy;
        #1;
        slot   = !m_txv || rdy;
        exp_rr = (m_state == 2 && slot) ? (N'(1) << m_g) : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
        if (bus.tx_valid && bus.tx_ready) wire_q.push_back(bus.tx_data);

        if (reset) begin
            model_reset();
        end else begin
            m_pulse = 1'b0;
            case (m_state)
                0: if (v != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_ptr + k) % N;
                        if (!found && v[idx]) begin m_g = idx; found = 1'b1; end
                    end
                    m_state = TAG_ON ? 1 : 2;
                    m_busy  = 1'b1;
                    m_idle  = 0;
                end
                1: if (slot) begin
                    load = 1'b1; ld = TAG | 8'(m_g); m_state = 2;
                end
                default: begin
                    if (v[m_g] && slot) begin
                        load = 1'b1; ld = d[8*m_g +: 8]; last_acc = m_g; m_idle = 0;
                        if (l[m_g]) begin
                            m_state = 0; m_busy = 1'b0; m_ptr = (m_g + 1) % N;
                        end
                    end else if (!v[m_g]) begin
                        m_idle++;
                        if (m_idle == TO) begin
                            m_state = 0; m_busy = 1'b0; m_ptr = (m_g + 1) % N;
                            m_pulse = 1'b1; m_idle = 0;
                        end
                    end
                end
            endcase
            if (load) begin
                m_txv = 1'b1; m_txd = ld;
            end else if (m_txv && rdy) begin
                m_txv = 1'b0;
            end
            if (last_acc >= 0) void'(srcq[last_acc].pop_front());
        end

        @(posedge clk);
        @(negedge clk);
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("grant_id", 32'(bus.grant_id), 32'(m_g));
        chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_pulse));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wire_q.delete();
    endtask

    task automatic drain(input string tag, input int max);
        int  k;
        bit  done;
        done = 1'b0;
        for (k = 0; k < max && !done; k++) begin
            tick();
            done = (m_state == 0) && !m_txv;
            for (int i = 0; i < N; i++) if (srcq[i].size() != 0) done = 1'b0;
        end
        chk({tag, "_drained"}, 32'(done), 32'd1);
    endtask

    initial begin
        int acc_k, pulse_k, pre;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset values.
        do_reset();
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // Single requester 1, ready tied high, then pointer must sit at 2.
        rdy_val = 1'b1;
        enq(1, 3, 8'h41, 1'b1); expp(1, 3, 8'h41);
        drain("single", 40);
        chk_wire("single");
        enq(2, 1, 8'hB1, 1'b1); enq(1, 1, 8'hA1, 1'b1);
        expp(2, 1, 8'hB1); expp(1, 1, 8'hA1);
        drain("ptr2", 40);
        chk_wire("ptr2");

        // Requesters 0 and 2 contending: order 0, 2, 0, 2.
        do_reset();
        enq(0, 3, 8'h01, 1'b1); enq(0, 3, 8'h04, 1'b1);
        enq(2, 3, 8'h21, 1'b1); enq(2, 3, 8'h24, 1'b1);
        expp(0, 3, 8'h01); expp(2, 3, 8'h21); expp(0, 3, 8'h04); expp(2, 3, 8'h24);
        drain("rr", 80);
        chk_wire("rr");

        // Transmitter stall: byte held stable, no ready, resumes in the release cycle.
        do_reset();
        enq(3, 3, 8'h31, 1'b1); expp(3, 3, 8'h31);
        pre = TAG_ON ? 3 : 2;
        for (int k = 0; k < pre; k++) tick();
        rdy_val = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("stall_valid", 32'(bus.tx_valid), 32'd1);
            chk("stall_data", 32'(bus.tx_data), 32'h31);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        rdy_val = 1'b1;
        bus.tx_ready = 1'b1;
        #1;
        chk("release_ready", 32'(bus.req_ready), 32'h8);
        drain("stall", 40);
        chk_wire("stall");

        // Idle timeout of the owner after one byte, then requester 3 proceeds.
        do_reset();
        enq(1, 1, 8'h11, 1'b0); enq(3, 1, 8'h3A, 1'b1);
        expp(1, 1, 8'h11); expp(3, 1, 8'h3A);
        acc_k = -100; pulse_k = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (last_acc == 1) acc_k = k;
            if (bus.timeout_pulse && pulse_k < 0) pulse_k = k;
        end
        chk("timeout_gap", 32'(pulse_k - acc_k), 32'd8);
        drain("timeout", 40);
        chk_wire("timeout");

        // Reset mid-packet drops byte and grant; requester 0 then starts cleanly.
        do_reset();
        enq(2, 5, 8'h71, 1'b1);
        pre = TAG_ON ? 4 : 3;
        for (int k = 0; k < pre; k++) tick();
        do_reset();
        chk("midrst_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_grant", 32'(bus.grant_id), 32'd0);
        srcq[2].delete();
        enq(0, 2, 8'h0A, 1'b1); expp(0, 2, 8'h0A);
        drain("midrst", 40);
        chk_wire("midrst");

        // One-byte packet from requester 2: header presence follows the build option.
        enq(2, 1, 8'h55, 1'b1); expp(2, 1, 8'h55);
        drain("tag", 40);
        chk_wire("tag");

        // Random traffic with random gaps and transmitter backpressure.
        rnd_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int id, n;
                id = $urandom_range(0, N - 1);
                n  = $urandom_range(1, 4);
                if (srcq[id].size() < 8)
                    for (int k = 0; k < n; k++)
                        srcq[id].push_back({(k == n - 1), 8'($urandom_range(0, 255))});
            end
            tick();
        end
        drain("random", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
